// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op codes, state encoding and size defaults for shift_seq
// Purpose: single source of the shift op encodings, FSM states and the
//          default data/shift-amount widths used by shift_seq and its parts.
// Ports:   none (package).
package shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  // 2'b11 is not named: every consumer treats it as a left shift.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// rtl/shift_seq_if.sv - request/result interface between a shift_seq user and the sequencer
// Purpose: bundles the request (start, A, shamt, op) and result
//          (ready, busy, result, result_valid) signals.
// Ports:   master - requester side (drives start/A/shamt/op)
//          slave  - sequencer side (drives ready/busy/result/result_valid)
interface shift_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);

  logic               start;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         op;
  logic               ready;
  logic               busy;
  logic [WIDTH-1:0]   result;
  logic               result_valid;

  modport master (
    output start, A, shamt, op,
    input  ready, busy, result, result_valid
  );

  modport slave (
    input  start, A, shamt, op,
    output ready, busy, result, result_valid
  );

endinterface

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - combinational shift of a word by 2^amt_sel
// Purpose: one power-of-two shift step; the sequencer reuses it for every stage.
// Ports:   in      - word to shift
//          op      - OP_SLL / OP_SRL / OP_SRA (2'b11 shifts left)
//          amt_sel - stage index, shift distance is 2^amt_sel
//          out     - shifted word
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic [IDX_W-1:0] amt_sel,
  output logic [WIDTH-1:0] out
);

  logic [31:0] w_amt;

  assign w_amt = 32'd1 << amt_sel;

  always_comb begin
    out = in << w_amt;
    case (op)
      OP_SRL:  out = in >> w_amt;
      // The word's MSB still holds the operand's sign bit, so an
      // arithmetic shift of the working value replicates it correctly.
      OP_SRA:  out = WIDTH'($signed(in) >>> w_amt);
      default: out = in << w_amt;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle barrel shifter walking shamt one bit per cycle
// Purpose: captures an operand and shift amount, then applies one 2^idx
//          shift per cycle for each set shamt bit up to the highest one.
// Ports:   clock   - rising-edge clock
//          reset_n - synchronous active-low reset
//          bus     - shift_seq_if slave: start/A/shamt/op in,
//                    ready/busy/result/result_valid out
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  shift_seq_if.slave bus
);

  localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_rem;
  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_op;

  logic               w_accept;
  logic [SHAMT_W-1:0] w_rem_clr;
  logic [WIDTH-1:0]   w_stage_out;

  assign w_accept  = (r_state == ST_IDLE) && bus.start;
  // rem with the current stage's bit retired; zero means this is the last stage.
  assign w_rem_clr = r_rem & ~(SHAMT_W'(1) << r_idx);

  shift_stage #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_stage (
    .in      (r_work),
    .op      (r_op),
    .amt_sel (r_idx),
    .out     (w_stage_out)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_rem_clr == '0) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_work <= '0;
      r_rem  <= '0;
      r_idx  <= '0;
      r_op   <= OP_SLL;
    end else if (w_accept) begin
      r_work <= bus.A;
      r_rem  <= bus.shamt;
      r_idx  <= '0;
      r_op   <= bus.op;
    end else if (r_state == ST_SHIFT) begin
      if (r_rem[r_idx]) begin
        r_work <= w_stage_out;
      end
      r_rem <= w_rem_clr;
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Outputs
  always_comb begin
    bus.ready        = (r_state == ST_IDLE);
    bus.busy         = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    bus.result_valid = (r_state == ST_DONE);
    bus.result       = r_work;
  end

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - self-checking bench for shift_seq
module tb_shift_seq;

  localparam int W  = 32;
  localparam int SW = 5;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  shift_seq_if #(.WIDTH(W), .SHAMT_W(SW)) bus_if ();

  shift_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s, input logic [1:0] op);
    logic [63:0] ext;
    logic [63:0] sh;
    case (op)
      2'b01: begin ext = {32'h0, a}; sh = ext >> s; end
      2'b10: begin ext = {{32{a[31]}}, a}; sh = ext >> s; end
      default: begin ext = {32'h0, a}; sh = ext << s; end
    endcase
    return sh[31:0];
  endfunction

  function automatic int ref_lat(input int s);
    int h;
    if (s == 0) return 1;
    h = 0;
    for (int b = 0; b < SW; b++) if (((s >> b) & 1) == 1) h = b;
    return h + 2;
  endfunction

  // Drives one request in the current (IDLE) cycle, waits for the pulse and
  // returns the cycles from the accepting edge plus the result seen.
  task automatic run_op(input logic [31:0] a, input int s, input logic [1:0] op,
                        output int lat, output logic [31:0] res);
    bus_if.start = 1'b1;
    bus_if.A     = a;
    bus_if.shamt = SW'(s);
    bus_if.op    = op;
    @(posedge clock); #1;
    bus_if.start = 1'b0;
    bus_if.A     = $urandom;
    bus_if.shamt = SW'($urandom);
    bus_if.op    = 2'($urandom);
    lat = 1;
    while (!bus_if.result_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    res = bus_if.result;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic [31:0] a;
    int          s;
    logic [1:0]  op;
    n_cmp = 0;
    n_err = 0;

    // Reset with start held high
    reset_n      = 1'b0;
    bus_if.start = 1'b1;
    bus_if.A     = 32'hDEAD_BEEF;
    bus_if.shamt = 5'd7;
    bus_if.op    = 2'b01;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_ready", 64'(bus_if.ready), 64'd1);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_result", 64'(bus_if.result), 64'd0);
    chk("rst_valid", 64'(bus_if.result_valid), 64'd0);
    bus_if.start = 1'b0;
    reset_n      = 1'b1;
    @(posedge clock); #1;

    // SLL by 31
    run_op(32'h0000_0001, 31, 2'b00, lat, res);
    chk("sll31_lat", 64'(lat), 64'd6);
    chk("sll31_res", 64'(res), 64'h8000_0000);
    @(posedge clock); #1;
    chk("sll31_pulse", 64'(bus_if.result_valid), 64'd0);
    chk("sll31_hold", 64'(bus_if.result), 64'h8000_0000);
    chk("sll31_ready", 64'(bus_if.ready), 64'd1);

    // SRA / SRL by 4
    run_op(32'h8000_0000, 4, 2'b10, lat, res);
    chk("sra4_lat", 64'(lat), 64'd4);
    chk("sra4_res", 64'(res), 64'hF800_0000);
    @(posedge clock); #1;
    run_op(32'h8000_0000, 4, 2'b01, lat, res);
    chk("srl4_lat", 64'(lat), 64'd4);
    chk("srl4_res", 64'(res), 64'h0800_0000);
    @(posedge clock); #1;

    // op 2'b11 behaves as SLL
    run_op(32'h0000_00F0, 9, 2'b11, lat, res);
    chk("op11_res", 64'(res), 64'h0001_E000);
    @(posedge clock); #1;

    // shamt = 0
    run_op(32'h1234_5678, 0, 2'b01, lat, res);
    chk("sh0_lat", 64'(lat), 64'd1);
    chk("sh0_res", 64'(res), 64'h1234_5678);
    @(posedge clock); #1;
    chk("sh0_pulse", 64'(bus_if.result_valid), 64'd0);

    // Second start mid-operation is ignored
    bus_if.start = 1'b1;
    bus_if.A     = 32'h0000_0005;
    bus_if.shamt = 5'd3;
    bus_if.op    = 2'b00;
    @(posedge clock); #1;
    chk("busy_n1", 64'(bus_if.busy), 64'd1);
    bus_if.A     = 32'hFFFF_FFFF;
    bus_if.shamt = 5'd17;
    bus_if.op    = 2'b10;
    @(posedge clock); #1;
    bus_if.start = 1'b0;
    @(posedge clock); #1;
    chk("restart_valid", 64'(bus_if.result_valid), 64'd1);
    chk("restart_res", 64'(bus_if.result), 64'h0000_0028);
    @(posedge clock); #1;
    chk("restart_idle", 64'(bus_if.ready), 64'd1);

    // Reset during the operation suppresses the pulse
    bus_if.start = 1'b1;
    bus_if.A     = 32'h0000_0005;
    bus_if.shamt = 5'd3;
    bus_if.op    = 2'b00;
    @(posedge clock); #1;
    bus_if.start = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("abort_ready", 64'(bus_if.ready), 64'd1);
    chk("abort_valid", 64'(bus_if.result_valid), 64'd0);
    chk("abort_result", 64'(bus_if.result), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk("abort_nopulse", 64'(bus_if.result_valid), 64'd0);
    end

    // Random back-to-back operations
    for (int i = 0; i < 4000; i++) begin
      a  = $urandom;
      s  = int'($urandom_range(0, 31));
      op = 2'($urandom);
      if (i % 16 == 0) s = 0;
      if (i % 16 == 1) s = 31;
      run_op(a, s, op, lat, res);
      chk("rand_lat", 64'(lat), 64'(ref_lat(s)));
      chk("rand_res", 64'(res), 64'(ref_shift(a, s, op)));
      @(posedge clock); #1;
      chk("rand_ready", 64'(bus_if.ready), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
